emu_sdram_rq_arbiter: RTL and testbench
=======================================

// Module: emu_sdram_rq_arbiter
// PURPOSE
//  Parametrised N-channel ROM fetch front-end between the core's per-channel SDRAM
//  request ports and one shared SDRAM read port.
//  Generalises the fixed MAINCPU/OBJROM request pair at the core top to NCH channels,
//  with selectable arbitration and a one-entry hold/hit register per channel.
//  A hit (same address as the last fetch) is answered locally without an SDRAM access.
// PARAMETERS
//  NCH        4   number of request channels (1..8)
//  AW         17  per-channel byte address width
//  DW         8   data width
//  PRIO_MODE  0   0 = round-robin, 1 = fixed priority (ch0 highest)
//  HOLD_EN    1   1 = per-channel hit register enabled, 0 = every request goes to SDRAM
// PORTS
//  i_EMU_MCLK        in   1          master clock, all logic on rising edge
//  i_EMU_INITRST_n   in   1          asynchronous active-low reset
//  i_FLUSH           in   1          invalidate all hit registers (ROM reload)
//  i_CH_RQ_n         in   NCH        per-channel request strobe, active low, 1 clk wide
//  i_CH_ADDR         in   NCH*AW     per-channel address, ch c at [c*AW +: AW]
//  o_CH_DATA         out  NCH*DW     per-channel read data, held until next completion
//  o_CH_RDY          out  NCH        per-channel completion pulse, 1 clk
//  o_SDR_RQ          out  1          SDRAM read request, level until acked
//  o_SDR_ADDR        out  AW+CW      {channel index (CW = clog2(NCH), min 1), address}
//  i_SDR_ACK         in   1          SDRAM accepted request (1 clk)
//  i_SDR_DVALID      in   1          read data valid (1 clk)
//  i_SDR_DATA        in   DW         read data
// BEHAVIOUR
//  Reset: o_CH_DATA=0, o_CH_RDY=0, o_SDR_RQ=0, o_SDR_ADDR=0.
//   Reset also clears all pending flags and valid bits and sets the RR pointer to ch0.
//  Capture: RQ_n low at edge t latches ADDR[c] into pend_addr[c].
//   On a hit (HOLD_EN & valid[c] & pend_addr==held_addr[c]), o_CH_RDY[c]=1 at t+1 and data is unchanged.
//   On a miss, pend[c] is set at t+1.
//   A new RQ_n on a channel whose pend is set is ignored; the pending request is not disturbed.
//  FSM IDLE/ISSUE/WAIT; only one SDRAM transaction is outstanding.
//   IDLE: if any pend, grant one channel g and go to ISSUE.
//    Round-robin: search starts at the channel after the last grant.
//    Fixed priority: lowest index wins.
//   ISSUE: o_SDR_RQ=1 and o_SDR_ADDR={g, pend_addr[g]}, held until the cycle i_SDR_ACK=1, then WAIT.
//    o_SDR_RQ drops the cycle after ACK.
//   WAIT: on i_SDR_DVALID, latch i_SDR_DATA into o_CH_DATA[g] and held_addr[g]; set valid[g].
//    Clear pend[g], pulse o_CH_RDY[g] at the next edge, go to IDLE.
//    A new grant is possible in the same IDLE cycle that follows.
//  Miss latency, idle bus, ACK same cycle as RQ, DVALID k clks after ACK:
//   RQ_n@t, pend@t+1, ISSUE@t+2, WAIT@t+3, RDY@t+3+k.
//  DVALID or ACK outside the expected state: ignored.
//  i_FLUSH: clears all valid bits at the next edge.
//   If asserted during WAIT, the in-flight data is still delivered with RDY, but valid[g] stays 0.
//   A hit lookup in the same cycle as FLUSH is treated as a miss.
//  Simultaneous DVALID for ch g and a new RQ_n on ch g:
//   the request compares against the pre-update held_addr, so it misses and becomes pending.
//  Reset mid-transaction: everything returns to reset values.
//   A late DVALID after reset is ignored (FSM is in IDLE).
//  PRIO_MODE=1 may starve high channels; this is intended for CPU-first systems.
// TESTING
//  T1 hit path:
//   ch1 reads 0x00123, SDRAM returns 0x5A; repeat the same address
//   -> RDY[1] 1 clk after strobe, data 0x5A, no o_SDR_RQ.
//  T2 miss latency:
//   ch0 reads 0x00010, ACK same cycle, DVALID 3 clks later with 0xC3
//   -> o_SDR_ADDR={0,0x00010}, RDY[0]@t+6, data 0xC3.
//  T3 round-robin:
//   ch0..ch3 strobe in the same cycle, PRIO_MODE=0 -> grants 0,1,2,3.
//   Re-strobe ch0 and ch2 -> grants 0 then 2.
//   With PRIO_MODE=1 and ch3+ch0 pending -> ch0 first.
//  T4 flush in WAIT:
//   ch2 miss in flight, FLUSH, DVALID 0x77 -> RDY[2] with 0x77.
//   Repeat the same address -> goes to SDRAM (miss).
//  T5 ignore while pending:
//   ch1 strobes 0x100 then 0x200 before completion -> only 0x100 fetched, one RDY.
//  T6 reset mid-WAIT:
//   assert reset during WAIT, release, then pulse DVALID -> no RDY; all outputs 0.

Source files
------------

// File: rtl/emu_sdram_rq_arbiter.sv
// N-channel ROM fetch front-end: per-channel hit register plus an arbiter that
// funnels misses into one shared SDRAM read port, one transaction at a time.
module emu_sdram_rq_arbiter #(
    parameter int NCH       = 4,
    parameter int AW        = 17,
    parameter int DW        = 8,
    parameter int PRIO_MODE = 0,
    parameter int HOLD_EN   = 1,
    localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                i_EMU_MCLK,
    input  logic                i_EMU_INITRST_n,
    input  logic                i_FLUSH,
    input  logic [NCH-1:0]      i_CH_RQ_n,
    input  logic [NCH*AW-1:0]   i_CH_ADDR,
    output logic [NCH*DW-1:0]   o_CH_DATA,
    output logic [NCH-1:0]      o_CH_RDY,
    output logic                o_SDR_RQ,
    output logic [AW+CW-1:0]    o_SDR_ADDR,
    input  logic                i_SDR_ACK,
    input  logic                i_SDR_DVALID,
    input  logic [DW-1:0]       i_SDR_DATA
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  gnt_q, gnt_d;
    logic [CW-1:0]  ptr_q, ptr_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] valid_q, valid_d;
    logic [NCH-1:0] rdy_q, rdy_d;
    logic           flush_pend_q, flush_pend_d;
    logic [AW-1:0]  pend_addr_q [NCH];
    logic [AW-1:0]  pend_addr_d [NCH];
    logic [AW-1:0]  held_addr_q [NCH];
    logic [AW-1:0]  held_addr_d [NCH];
    logic [DW-1:0]  data_q [NCH];
    logic [DW-1:0]  data_d [NCH];

    logic [AW-1:0]  ch_addr [NCH];
    logic [NCH-1:0] done;
    logic [NCH-1:0] accept;
    logic [NCH-1:0] hit;
    logic           grant_any;
    logic [CW-1:0]  grant_idx;

    // A completing channel may accept a new strobe in the same cycle; its
    // lookup still sees the pre-update held address.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        assign ch_addr[gi]                = i_CH_ADDR[gi*AW +: AW];
        assign o_CH_DATA[gi*DW +: DW]     = data_q[gi];
        assign done[gi]   = (state_q == S_WAIT) && i_SDR_DVALID && (gnt_q == CW'(gi));
        assign accept[gi] = !i_CH_RQ_n[gi] && (!pend_q[gi] || done[gi]);
        assign hit[gi]    = (HOLD_EN != 0) && valid_q[gi] && !i_FLUSH
                            && (ch_addr[gi] == held_addr_q[gi]);
    end

    assign o_CH_RDY = rdy_q;

    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        // Walk from the farthest candidate back to the nearest so the last hit wins.
        for (int k = NCH - 1; k >= 0; k--) begin
            if (PRIO_MODE != 0) begin
                idx = k;
            end else begin
                idx = int'(ptr_q) + k;
                if (idx >= NCH) idx = idx - NCH;
            end
            if (pend_q[idx]) begin
                grant_any = 1'b1;
                grant_idx = CW'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        ptr_d        = ptr_q;
        pend_d       = pend_q;
        valid_d      = valid_q;
        rdy_d        = '0;
        flush_pend_d = flush_pend_q;
        pend_addr_d  = pend_addr_q;
        held_addr_d  = held_addr_q;
        data_d       = data_q;
        o_SDR_RQ     = 1'b0;
        o_SDR_ADDR   = '0;

        case (state_q)
            S_IDLE: begin
                flush_pend_d = 1'b0;
                if (grant_any) begin
                    gnt_d   = grant_idx;
                    ptr_d   = (grant_idx == CW'(NCH - 1)) ? '0 : grant_idx + CW'(1);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_SDR_RQ   = 1'b1;
                o_SDR_ADDR = {gnt_q, pend_addr_q[gnt_q]};
                if (i_FLUSH) flush_pend_d = 1'b1;
                if (i_SDR_ACK) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_FLUSH) flush_pend_d = 1'b1;
                if (i_SDR_DVALID) begin
                    data_d[gnt_q]      = i_SDR_DATA;
                    held_addr_d[gnt_q] = pend_addr_q[gnt_q];
                    rdy_d[gnt_q]       = 1'b1;
                    pend_d[gnt_q]      = 1'b0;
                    // A flush seen while in flight keeps this entry invalid.
                    if (!flush_pend_q) valid_d[gnt_q] = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        for (int c = 0; c < NCH; c++) begin
            if (accept[c]) begin
                pend_addr_d[c] = ch_addr[c];
                if (hit[c]) rdy_d[c]  = 1'b1;
                else        pend_d[c] = 1'b1;
            end
        end

        if (i_FLUSH) valid_d = '0;
    end

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            ptr_q        <= '0;
            pend_q       <= '0;
            valid_q      <= '0;
            rdy_q        <= '0;
            flush_pend_q <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                pend_addr_q[c] <= '0;
                held_addr_q[c] <= '0;
                data_q[c]      <= '0;
            end
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            ptr_q        <= ptr_d;
            pend_q       <= pend_d;
            valid_q      <= valid_d;
            rdy_q        <= rdy_d;
            flush_pend_q <= flush_pend_d;
            pend_addr_q  <= pend_addr_d;
            held_addr_q  <= held_addr_d;
            data_q       <= data_d;
        end
    end
endmodule

// File: tb/tb_emu_sdram_rq_arbiter.sv
// Directed bench: a per-cycle vector table for hit/miss/ignore timing, then
// hand-written sequences for arbitration order, flush in flight and reset mid-wait.
module tb_emu_sdram_rq_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, f_flush;
    logic [3:0]  rq_n, f_rq_n;
    logic [67:0] ch_addr;
    logic        ack, dv, f_ack, f_dv;
    logic [7:0]  din;
    logic [31:0] ch_data, f_data;
    logic [3:0]  rdy, f_rdy;
    logic        sdr_rq, f_sdr_rq;
    logic [18:0] sdr_addr, f_sdr_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    emu_sdram_rq_arbiter #(.NCH(4), .AW(17), .DW(8), .PRIO_MODE(0), .HOLD_EN(1)) u_rr (
        .i_EMU_MCLK(clk), .i_EMU_INITRST_n(rst_n), .i_FLUSH(flush),
        .i_CH_RQ_n(rq_n), .i_CH_ADDR(ch_addr),
        .o_CH_DATA(ch_data), .o_CH_RDY(rdy),
        .o_SDR_RQ(sdr_rq), .o_SDR_ADDR(sdr_addr),
        .i_SDR_ACK(ack), .i_SDR_DVALID(dv), .i_SDR_DATA(din)
    );

    emu_sdram_rq_arbiter #(.NCH(4), .AW(17), .DW(8), .PRIO_MODE(1), .HOLD_EN(1)) u_fix (
        .i_EMU_MCLK(clk), .i_EMU_INITRST_n(rst_n), .i_FLUSH(f_flush),
        .i_CH_RQ_n(f_rq_n), .i_CH_ADDR(ch_addr),
        .o_CH_DATA(f_data), .o_CH_RDY(f_rdy),
        .o_SDR_RQ(f_sdr_rq), .o_SDR_ADDR(f_sdr_addr),
        .i_SDR_ACK(f_ack), .i_SDR_DVALID(f_dv), .i_SDR_DATA(din)
    );

    typedef struct {
        logic [3:0]  rq_n;
        logic [16:0] addr;
        logic        ack;
        logic        dv;
        logic [7:0]  din;
        logic [3:0]  e_rdy;
        logic        e_rq;
        logic [18:0] e_addr;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input logic [3:0] r, input logic [16:0] a, input logic k,
                                input logic v, input logic [7:0] d, input logic [3:0] er,
                                input logic eq, input logic [18:0] ea, input logic [31:0] ed);
        vec_t t;
        t.rq_n = r; t.addr = a; t.ack = k; t.dv = v; t.din = d;
        t.e_rdy = er; t.e_rq = eq; t.e_addr = ea; t.e_data = ed;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
        end
    endtask

    task automatic strobe(input bit fix, input logic [3:0] r, input logic [16:0] a);
        ch_addr = {4{a}};
        if (fix) f_rq_n = r; else rq_n = r;
        @(posedge clk); #1;
        rq_n = 4'hF; f_rq_n = 4'hF;
    endtask

    task automatic serve(input bit fix, input int ch, input logic [16:0] a,
                         input logic [7:0] d, input bit flush_mid);
        int n;
        logic [18:0] ea;
        logic [31:0] one;
        n = 0;
        ea = {ch[1:0], a};
        one = 32'd1 << ch;
        while (((fix ? f_sdr_rq : sdr_rq) == 1'b0) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("ch%0d_grant_rq", ch), {31'd0, (fix ? f_sdr_rq : sdr_rq)}, 32'd1);
        chk($sformatf("ch%0d_grant_addr", ch), {13'd0, (fix ? f_sdr_addr : sdr_addr)}, {13'd0, ea});
        if (fix) f_ack = 1'b1; else ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0; f_ack = 1'b0;
        chk($sformatf("ch%0d_rq_drop", ch), {31'd0, (fix ? f_sdr_rq : sdr_rq)}, 32'd0);
        if (flush_mid) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
        end
        din = d;
        if (fix) f_dv = 1'b1; else dv = 1'b1;
        @(posedge clk); #1;
        dv = 1'b0; f_dv = 1'b0;
        chk($sformatf("ch%0d_rdy", ch), {28'd0, (fix ? f_rdy : rdy)}, one);
        chk($sformatf("ch%0d_data", ch), {24'd0, (fix ? f_data[ch*8 +: 8] : ch_data[ch*8 +: 8])}, {24'd0, d});
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_data"}, ch_data, 32'd0);
        chk({tag, "_rdy"}, {28'd0, rdy}, 32'd0);
        chk({tag, "_sdr_rq"}, {31'd0, sdr_rq}, 32'd0);
        chk({tag, "_sdr_addr"}, {13'd0, sdr_addr}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; f_flush = 1'b0;
        rq_n = 4'hF; f_rq_n = 4'hF; ch_addr = '0;
        ack = 1'b0; dv = 1'b0; f_ack = 1'b0; f_dv = 1'b0; din = 8'h00;

        // T2 miss latency, T1 hit, T5 ignore-while-pending, stray ACK/DVALID in IDLE
        tbl[0]  = mk(4'b1110, 17'h00010, 0, 0, 8'h00, 4'b0000, 0, 19'h00000, 32'h00000000);
        tbl[1]  = mk(4'b1111, 17'h00000, 0, 0, 8'h00, 4'b0000, 1, 19'h00010, 32'h00000000);
        tbl[2]  = mk(4'b1111, 17'h00000, 1, 0, 8'h00, 4'b0000, 0, 19'h00000, 32'h00000000);
        tbl[3]  = mk(4'b1111, 17'h00000, 0, 0, 8'h00, 4'b0000, 0, 19'h00000, 32'h00000000);
        tbl[4]  = mk(4'b1111, 17'h00000, 0, 0, 8'h00, 4'b0000, 0, 19'h00000, 32'h00000000);
        tbl[5]  = mk(4'b1111, 17'h00000, 0, 1, 8'hC3, 4'b0001, 0, 19'h00000, 32'h000000C3);
        tbl[6]  = mk(4'b1111, 17'h00000, 0, 0, 8'h00, 4'b0000, 0, 19'h00000, 32'h000000C3);
        tbl[7]  = mk(4'b1101, 17'h00123, 0, 0, 8'h00, 4'b0000, 0, 19'h00000, 32'h000000C3);
        tbl[8]  = mk(4'b1111, 17'h00000, 0, 0, 8'h00, 4'b0000, 1, 19'h20123, 32'h000000C3);
        tbl[9]  = mk(4'b1111, 17'h00000, 1, 0, 8'h00, 4'b0000, 0, 19'h00000, 32'h000000C3);
        tbl[10] = mk(4'b1111, 17'h00000, 0, 1, 8'h5A, 4'b0010, 0, 19'h00000, 32'h00005AC3);
        tbl[11] = mk(4'b1101, 17'h00123, 0, 0, 8'h00, 4'b0010, 0, 19'h00000, 32'h00005AC3);
        tbl[12] = mk(4'b1111, 17'h00000, 0, 0, 8'h00, 4'b0000, 0, 19'h00000, 32'h00005AC3);
        tbl[13] = mk(4'b1101, 17'h00100, 0, 0, 8'h00, 4'b0000, 0, 19'h00000, 32'h00005AC3);
        tbl[14] = mk(4'b1101, 17'h00200, 0, 0, 8'h00, 4'b0000, 1, 19'h20100, 32'h00005AC3);
        tbl[15] = mk(4'b1101, 17'h00200, 1, 0, 8'h00, 4'b0000, 0, 19'h00000, 32'h00005AC3);
        tbl[16] = mk(4'b1111, 17'h00000, 0, 1, 8'h11, 4'b0010, 0, 19'h00000, 32'h000011C3);
        tbl[17] = mk(4'b1111, 17'h00000, 0, 0, 8'h00, 4'b0000, 0, 19'h00000, 32'h000011C3);
        tbl[18] = mk(4'b1111, 17'h00000, 0, 0, 8'h00, 4'b0000, 0, 19'h00000, 32'h000011C3);
        tbl[19] = mk(4'b1111, 17'h00000, 1, 1, 8'hFF, 4'b0000, 0, 19'h00000, 32'h000011C3);

        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        chk("reset_fix_rq", {31'd0, f_sdr_rq}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            rq_n = tbl[i].rq_n; ch_addr = {4{tbl[i].addr}};
            ack = tbl[i].ack; dv = tbl[i].dv; din = tbl[i].din;
            @(posedge clk); #1;
            chk($sformatf("row%0d_rdy", i), {28'd0, rdy}, {28'd0, tbl[i].e_rdy});
            chk($sformatf("row%0d_sdr_rq", i), {31'd0, sdr_rq}, {31'd0, tbl[i].e_rq});
            chk($sformatf("row%0d_sdr_addr", i), {13'd0, sdr_addr}, {13'd0, tbl[i].e_addr});
            chk($sformatf("row%0d_data", i), ch_data, tbl[i].e_data);
            $display("row %0d: rq_n=%b rdy=%b sdr_rq=%b sdr_addr=%h data=%h",
                     i, tbl[i].rq_n, rdy, sdr_rq, sdr_addr, ch_data);
        end
        rq_n = 4'hF; ack = 1'b0; dv = 1'b0;

        // T3 round-robin from a fresh pointer
        do_reset();
        strobe(0, 4'b0000, 17'h00040);
        for (int g = 0; g < 4; g++) serve(0, g, 17'h00040, 8'h80 + 8'(g), 0);
        strobe(0, 4'b1010, 17'h00050);
        serve(0, 0, 17'h00050, 8'h90, 0);
        serve(0, 2, 17'h00050, 8'h92, 0);
        // pointer now sits at ch3, so ch3 beats ch0
        strobe(0, 4'b0110, 17'h00060);
        serve(0, 3, 17'h00060, 8'hA3, 0);
        serve(0, 0, 17'h00060, 8'hA0, 0);
        $display("T3 round-robin sequence done");

        // T3 fixed priority: ch0 before ch3
        strobe(1, 4'b0110, 17'h00070);
        serve(1, 0, 17'h00070, 8'hB0, 0);
        serve(1, 3, 17'h00070, 8'hB3, 0);
        $display("T3 fixed-priority sequence done");

        // T4 flush while in flight
        strobe(0, 4'b1011, 17'h00222);
        chk("t4_first_rdy", {28'd0, rdy}, 32'd0);
        serve(0, 2, 17'h00222, 8'h77, 1);
        strobe(0, 4'b1011, 17'h00222);
        chk("t4_repeat_miss_rdy", {28'd0, rdy}, 32'd0);
        serve(0, 2, 17'h00222, 8'h78, 0);
        $display("T4 flush sequence done");

        // T6 reset mid-WAIT, then a stray DVALID
        strobe(0, 4'b1110, 17'h00099);
        for (int n = 0; n < 20 && !sdr_rq; n++) begin
            @(posedge clk); #1;
        end
        chk("t6_issue", {31'd0, sdr_rq}, 32'd1);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("t6_in_reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        din = 8'hEE; dv = 1'b1;
        @(posedge clk); #1;
        dv = 1'b0;
        chk_idle_outputs("t6_late_dvalid");
        @(posedge clk); #1;
        chk("t6_no_reissue", {31'd0, sdr_rq}, 32'd0);
        $display("T6 reset sequence done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
